// File: rtl/sdp_nrdma_bn_operand_align.sv
// sdp_nrdma_bn_operand_align: joins N-RDMA ALU/MUL operand streams into registered BN operand beats.
// Optional stall counter output dp2reg_align_stall when SDP_NRDMA_ALIGN_PERF_EN is defined.
module sdp_nrdma_bn_operand_align #(
   parameter int DW  = 128,
   parameter int CPW = 8
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          op_load,
   input  logic [1:0]    reg2dp_nrdma_data_use,
   input  logic          reg2dp_nrdma_data_mode,
   input  logic [12:0]   reg2dp_width,
   input  logic [12:0]   reg2dp_height,
   input  logic [12:0]   reg2dp_channel,
   input  logic          nrdma_alu_valid,
   output logic          nrdma_alu_ready,
   input  logic [DW-1:0] nrdma_alu_pd,
   input  logic          nrdma_mul_valid,
   output logic          nrdma_mul_ready,
   input  logic [DW-1:0] nrdma_mul_pd,
   output logic          bn_op_valid,
   input  logic          bn_op_ready,
   output logic [DW-1:0] bn_op_alu_pd,
   output logic [DW-1:0] bn_op_mul_pd,
   output logic          bn_op_last,
   output logic          layer_done
`ifdef SDP_NRDMA_ALIGN_PERF_EN
   ,
   output logic [31:0]   dp2reg_align_stall
`endif
);
   typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
   state_t      state, state_nxt;
   logic        use_alu, use_mul, mode;
   logic [25:0] spat_m1, sp_cnt, sp_nxt;
   logic [12:0] grp_m1, grp_cnt, grp_nxt;
   logic [26:0] spat;
   logic        load, accept, at_sp_end, at_last, in_ok, fetch_slot, pop;
   assign spat       = ({14'd0, reg2dp_width} + 27'd1) * ({14'd0, reg2dp_height} + 27'd1);
   assign load       = state == IDLE && op_load;
   assign accept     = bn_op_valid && bn_op_ready;
   assign at_sp_end  = sp_cnt == spat_m1;
   assign at_last    = at_sp_end && grp_cnt == grp_m1;
   assign in_ok      = (!use_alu || nrdma_alu_valid) && (!use_mul || nrdma_mul_valid);
   // per-element mode refills the output register in the same cycle the current beat leaves
   assign fetch_slot = state == FETCH || (state == EMIT && mode && accept && !at_last);
   assign pop        = fetch_slot && in_ok;
   assign nrdma_alu_ready = fetch_slot && use_alu && (!use_mul || nrdma_mul_valid);
   assign nrdma_mul_ready = fetch_slot && use_mul && (!use_alu || nrdma_alu_valid);
   assign sp_nxt  = load ? 26'd0 : !accept ? sp_cnt : at_sp_end ? 26'd0 : sp_cnt + 26'd1;
   assign grp_nxt = load ? 13'd0 : (accept && at_sp_end && grp_cnt != grp_m1) ? grp_cnt + 13'd1 : grp_cnt;
   assign state_nxt = state == IDLE  ? (op_load ? FETCH : IDLE) :
                      state == FETCH ? (pop ? EMIT : FETCH) :
                      state == EMIT  ? (!accept ? EMIT : at_last ? DONE :
                                        mode ? (pop ? EMIT : FETCH) : (at_sp_end ? FETCH : EMIT)) :
                      IDLE;
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state        <= IDLE;
         use_alu      <= 1'b0;
         use_mul      <= 1'b0;
         mode         <= 1'b0;
         spat_m1      <= '0;
         grp_m1       <= '0;
         sp_cnt       <= '0;
         grp_cnt      <= '0;
         bn_op_valid  <= 1'b0;
         bn_op_last   <= 1'b0;
         layer_done   <= 1'b0;
         bn_op_alu_pd <= '0;
         bn_op_mul_pd <= '0;
      end else begin
         state       <= state_nxt;
         sp_cnt      <= sp_nxt;
         grp_cnt     <= grp_nxt;
         bn_op_valid <= state_nxt == EMIT;
         bn_op_last  <= state_nxt == EMIT && sp_nxt == spat_m1 && grp_nxt == grp_m1;
         layer_done  <= state_nxt == DONE;
         if (load) begin
            use_alu <= reg2dp_nrdma_data_use != 2'd0;
            use_mul <= reg2dp_nrdma_data_use != 2'd1;
            mode    <= reg2dp_nrdma_data_mode;
            spat_m1 <= spat[25:0] - 26'd1;
            grp_m1  <= reg2dp_channel >> $clog2(CPW);
         end
         if (pop) begin
            bn_op_alu_pd <= use_alu ? nrdma_alu_pd : '0;
            bn_op_mul_pd <= use_mul ? nrdma_mul_pd : '0;
         end
      end
   end
`ifdef SDP_NRDMA_ALIGN_PERF_EN
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn)
         dp2reg_align_stall <= '0;
      else if (load)
         dp2reg_align_stall <= '0;
      else if ((state == FETCH || state == EMIT) && bn_op_ready && !bn_op_valid && dp2reg_align_stall != 32'hFFFF_FFFF)
         dp2reg_align_stall <= dp2reg_align_stall + 32'd1;
   end
`endif
endmodule
